dsp_codec_if: RTL

DSP_CODEC_IF -- requirements
Module: dsp_codec_if

---
 rtl/dsp_codec_if.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dsp_codec_if.sv
// dsp_codec_if: converter power sequencing, shared ADC/DAC sample clock divider,
// ADC capture on the rising sample edge and a one-word DAC holding register
// drained on the falling sample edge.
// Optional feature macro: DSP_CODEC_IF_TWOS_COMP_EN (flip each word's MSB,
// offset binary <-> two's complement, on both the ADC and DAC paths).
module dsp_codec_if #(
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned NCH        = 2,
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned WARMUP_CYC = 1024
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  enable,
    input  logic [NCH*DATA_W-1:0] adc_pins,
    output logic [NCH*DATA_W-1:0] dac_pins,
    output logic                  CLK_ADC,
    output logic                  CLK_DAC,
    output logic                  PWR_ON,
    output logic [NCH-1:0]        ADC_OE_N,
    output logic [NCH*DATA_W-1:0] adc_data,
    output logic                  adc_valid,
    input  logic [NCH*DATA_W-1:0] dac_data,
    input  logic                  dac_valid,
    output logic                  dac_ready,
    output logic                  dac_underrun,
    output logic                  running
);

    localparam int unsigned BUS_W = NCH * DATA_W;
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WU_W  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

`ifdef DSP_CODEC_IF_TWOS_COMP_EN
    localparam logic [BUS_W-1:0] MSB_FLIP = {NCH{{1'b1, {(DATA_W-1){1'b0}}}}};
`else
    localparam logic [BUS_W-1:0] MSB_FLIP = '0;
`endif

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [WU_W-1:0]   wcnt_q, wcnt_d;
    logic              sclk_q, sclk_d;
    logic              full_q, full_d;
    logic [BUS_W-1:0]  hold_q, hold_d;
    logic [BUS_W-1:0]  dac_pins_q, dac_pins_d;
    logic [BUS_W-1:0]  adc_data_q, adc_data_d;
    logic              adc_valid_q, adc_valid_d;
    logic              dac_ready_q, dac_ready_d;
    logic              underrun_q, underrun_d;
    logic              first_q, first_d;
    logic              pwr_q, pwr_d;
    logic [NCH-1:0]    oe_n_q, oe_n_d;
    logic              running_q, running_d;

    logic              div_wrap_c;
    logic              in_run_c;
    logic              rise_c;
    logic              fall_c;
    logic              accept_c;

    // Next-state decode: FSM transitions, divider, sample ticks and data paths
    always_comb begin
        state_d     = state_q;
        div_wrap_c  = (state_q != ST_OFF) && (div_q == DIV_W'(CLK_DIV - 1));
        in_run_c    = (state_q == ST_RUN) && enable;
        rise_c      = in_run_c && div_wrap_c && !sclk_q;
        fall_c      = in_run_c && div_wrap_c && sclk_q;
        accept_c    = in_run_c && dac_valid && dac_ready_q;

        case (state_q)
            ST_OFF:    if (enable) state_d = ST_WARMUP;
            ST_WARMUP: begin
                if (!enable)                                 state_d = ST_OFF;
                else if (wcnt_q == WU_W'(WARMUP_CYC - 1))    state_d = ST_RUN;
            end
            ST_RUN:    if (!enable) state_d = ST_OFF;
            default:   state_d = ST_OFF;
        endcase

        // warmup counter only advances while staying in WARMUP
        wcnt_d = ((state_q == ST_WARMUP) && (state_d == ST_WARMUP)) ? wcnt_q + 1'b1 : '0;

        // divider holds at zero in OFF so the first rising edge lands CLK_DIV cycles later
        if ((state_q == ST_OFF) || (state_d == ST_OFF)) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else begin
            div_d  = div_wrap_c ? '0 : div_q + 1'b1;
            sclk_d = div_wrap_c ? ~sclk_q : sclk_q;
        end

        // fall tick sees the pre-load occupancy; a same-cycle load stays for the next tick
        hold_d = accept_c ? dac_data : hold_q;
        if (state_d != ST_RUN)  full_d = 1'b0;
        else if (fall_c)        full_d = accept_c;
        else                    full_d = full_q | accept_c;

        dac_pins_d = (fall_c && full_q) ? (hold_q ^ MSB_FLIP) : dac_pins_q;

        if (state_d == ST_OFF) underrun_d = 1'b0;
        else                   underrun_d = underrun_q | (fall_c && !full_q && !first_q);

        // first fall tick after RUN entry is exempt from underrun detection
        if (state_d == ST_OFF)                                 first_d = 1'b0;
        else if ((state_q == ST_WARMUP) && (state_d == ST_RUN)) first_d = 1'b1;
        else if (fall_c)                                       first_d = 1'b0;
        else                                                   first_d = first_q;

        adc_data_d  = rise_c ? (adc_pins ^ MSB_FLIP) : adc_data_q;
        adc_valid_d = rise_c;

        dac_ready_d = (state_d == ST_RUN) && !full_d;
        pwr_d       = (state_d != ST_OFF);
        oe_n_d      = {NCH{state_d != ST_RUN}};
        running_d   = (state_d == ST_RUN);
    end

    // State and registered outputs; synchronous active-low reset has top priority
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_OFF;
            div_q       <= '0;
            wcnt_q      <= '0;
            sclk_q      <= 1'b0;
            full_q      <= 1'b0;
            hold_q      <= '0;
            dac_pins_q  <= '0;
            adc_data_q  <= '0;
            adc_valid_q <= 1'b0;
            dac_ready_q <= 1'b0;
            underrun_q  <= 1'b0;
            first_q     <= 1'b0;
            pwr_q       <= 1'b0;
            oe_n_q      <= '1;
            running_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            wcnt_q      <= wcnt_d;
            sclk_q      <= sclk_d;
            full_q      <= full_d;
            hold_q      <= hold_d;
            dac_pins_q  <= dac_pins_d;
            adc_data_q  <= adc_data_d;
            adc_valid_q <= adc_valid_d;
            dac_ready_q <= dac_ready_d;
            underrun_q  <= underrun_d;
            first_q     <= first_d;
            pwr_q       <= pwr_d;
            oe_n_q      <= oe_n_d;
            running_q   <= running_d;
        end
    end

    assign dac_pins     = dac_pins_q;
    assign CLK_ADC      = sclk_q;
    assign CLK_DAC      = sclk_q;
    assign PWR_ON       = pwr_q;
    assign ADC_OE_N     = oe_n_q;
    assign adc_data     = adc_data_q;
    assign adc_valid    = adc_valid_q;
    assign dac_ready    = dac_ready_q;
    assign dac_underrun = underrun_q;
    assign running      = running_q;

endmodule
